// File: rtl/serial_frame_receiver.sv
// Bit-banged serial frame receiver (cs_n / sclk / sdata, LSB first).
// Completed frames go into a small FIFO presented as valid/ready.
module serial_frame_receiver #(
    parameter int FRAME_BITS = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  sdata,
    input  logic                  cs_n,
    input  logic                  clear_flags,
    input  logic                  frame_ready,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  overrun,
    output logic                  short_frame,
    output logic                  busy
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

    logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic sdata_s1_q, sdata_s2_q;
    logic cs_s1_q, cs_s2_q, cs_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            sdata_s1_q  <= 1'b0;
            sdata_s2_q  <= 1'b0;
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_s1_q   <= sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            sdata_s1_q  <= sdata;
            sdata_s2_q  <= sdata_s1_q;
            cs_s1_q     <= cs_n;
            cs_s2_q     <= cs_s1_q;
            cs_prev_q   <= cs_s2_q;
        end
    end

    logic sclk_rise, cs_fall, cs_rise;
    assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
    assign cs_fall   = ~cs_s2_q & cs_prev_q;
    assign cs_rise   = cs_s2_q & ~cs_prev_q;

    state_t                state_q;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         count_q;
    logic                  short_q, busy_q;
    logic                  last_bit, push;

    generate
        if (FRAME_BITS == 1) begin : g_shift1
            assign shreg_d = sdata_s2_q;
        end else begin : g_shiftn
            assign shreg_d = {sdata_s2_q, shreg_q[FRAME_BITS-1:1]};
        end
    endgenerate

    assign last_bit = (count_q == CW'(FRAME_BITS - 1));
    // Final bit goes straight into the FIFO from the shift input, same cycle.
    assign push     = (state_q == SHIFT) && !cs_rise && sclk_rise && last_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            short_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            short_q <= 1'b0;
            case (state_q)
                IDLE: if (cs_fall) begin
                    shreg_q <= '0;
                    count_q <= '0;
                    state_q <= SHIFT;
                    busy_q  <= 1'b1;
                end
                SHIFT: if (cs_rise) begin
                    short_q <= (count_q != '0);
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else if (sclk_rise) begin
                    shreg_q <= shreg_d;
                    count_q <= count_q + CW'(1);
                    if (last_bit) state_q <= WAIT_CS;
                end
                WAIT_CS: if (cs_rise) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_q, rd_q;
    logic [PW:0]           cnt_q;
    logic                  overrun_q, full, pop, push_ok, drop;

    assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign pop     = frame_valid && frame_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= shreg_d;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            // A new overrun beats a simultaneous clear.
            if (drop)             overrun_q <= 1'b1;
            else if (clear_flags) overrun_q <= 1'b0;
        end
    end

    assign frame_data  = mem_q[rd_q];
    assign frame_valid = (cnt_q != '0);
    assign overrun     = overrun_q;
    assign short_frame = short_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: vector table plus corner sequences,
// frames checked through an expected-value queue as the FIFO pops them.
module tb_serial_frame_receiver;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0, sdata = 1'b0, cs_n = 1'b1;
    logic        clear_flags = 1'b0, frame_ready = 1'b0;
    logic [14:0] frame_data;
    logic        frame_valid, overrun, short_frame, busy;

    serial_frame_receiver #(.FRAME_BITS(15), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .sclk(sclk), .sdata(sdata), .cs_n(cs_n),
        .clear_flags(clear_flags), .frame_ready(frame_ready),
        .frame_data(frame_data), .frame_valid(frame_valid), .overrun(overrun),
        .short_frame(short_frame), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_pass = 0, short_cnt = 0;
    logic [14:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 2ns after a rising edge; outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (short_frame) short_cnt++;
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) check("unexpected_frame", {17'd0, frame_data}, 32'hFFFF_FFFF);
                else check("frame_data", {17'd0, frame_data}, {17'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_bits(input logic [31:0] v, input int n, input bit pop_on_last);
        for (int i = 0; i < n; i++) begin
            sdata = v[i];
            cyc(3);
            sclk = 1'b1;
            if (pop_on_last && i == n - 1) begin
                cyc(2);
                frame_ready = 1'b1;
                cyc(1);
                frame_ready = 1'b0;
                cyc(1);
            end else begin
                cyc(4);
            end
            sclk = 1'b0;
            cyc(1);
        end
    endtask

    task automatic send_frame(input logic [31:0] v, input int n, input bit pop_on_last);
        cs_n = 1'b0;
        cyc(4);
        send_bits(v, n, pop_on_last);
        cyc(3);
        cs_n = 1'b1;
        cyc(6);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc(1);
        cyc(2);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_valid_low"}, {31'd0, frame_valid}, 0);
    endtask

    typedef struct {
        logic [31:0] value;
        int          nbits;
        bit          expect_frame;
        bit          expect_short;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int s0;
        vecs[0] = '{32'h0000_001E, 15, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_7FFF,  7, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_7FFF, 15, 1'b1, 1'b0};
        vecs[3] = '{32'h0002_5555, 18, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0000, 15, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_4ABC, 15, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_1234,  0, 1'b0, 1'b0};

        cyc(3);
        reset = 1'b0;
        cyc(4);
        check("rst_valid", {31'd0, frame_valid}, 0);
        check("rst_data", {17'd0, frame_data}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        check("rst_short", {31'd0, short_frame}, 0);
        check("rst_busy", {31'd0, busy}, 0);

        frame_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            s0 = short_cnt;
            if (vecs[k].expect_frame) exp_q.push_back(vecs[k].value[14:0]);
            send_frame(vecs[k].value, vecs[k].nbits, 1'b0);
            drain($sformatf("vec%0d", k));
            check($sformatf("vec%0d_short", k), short_cnt - s0, {31'd0, vecs[k].expect_short});
            check($sformatf("vec%0d_overrun", k), {31'd0, overrun}, 0);
            check($sformatf("vec%0d_busy", k), {31'd0, busy}, 0);
        end

        // Stray sclk with cs_n high
        sclk = 1'b1;
        cyc(4);
        check("stray_busy_hi", {31'd0, busy}, 0);
        sclk = 1'b0;
        cyc(4);
        check("stray_busy_lo", {31'd0, busy}, 0);
        check("stray_valid", {31'd0, frame_valid}, 0);

        // Overrun: five frames into a four-deep FIFO with no reader
        frame_ready = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            if (f <= 4) exp_q.push_back(15'(f));
            send_frame(f, 15, 1'b0);
        end
        check("ovr_set", {31'd0, overrun}, 1);
        check("ovr_head", {17'd0, frame_data}, 1);
        frame_ready = 1'b1;
        drain("ovr");
        check("ovr_sticky", {31'd0, overrun}, 1);
        clear_flags = 1'b1;
        cyc(1);
        clear_flags = 1'b0;
        cyc(1);
        check("ovr_cleared", {31'd0, overrun}, 0);

        // Full FIFO with a pop in the very cycle the fifth frame is pushed
        frame_ready = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            exp_q.push_back(15'(f));
            send_frame(f, 15, f == 5);
        end
        check("fullpop_overrun", {31'd0, overrun}, 0);
        check("fullpop_pending", exp_q.size(), 4);
        frame_ready = 1'b1;
        drain("fullpop");

        // Reset in the middle of a frame
        s0 = short_cnt;
        cs_n = 1'b0;
        cyc(4);
        send_bits(32'h0000_7FFF, 8, 1'b0);
        check("mid_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        check("mid_busy_after_rst", {31'd0, busy}, 0);
        send_bits(32'h0000_7FFF, 7, 1'b0);
        cyc(3);
        cs_n = 1'b1;
        cyc(10);
        check("mid_no_frame", {31'd0, frame_valid}, 0);
        check("mid_no_short", short_cnt - s0, 0);
        exp_q.push_back(15'h1234);
        send_frame(32'h0000_1234, 15, 1'b0);
        drain("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
